// File: rtl/wb_trace_buffer_pkg.sv
// wb_trace_buffer_pkg: shared trace record layout and field offsets
package wb_trace_buffer_pkg;
  localparam int TRACE_REC_W = 70;
  localparam int PC_LSB = 38;
  localparam int VAL_LSB = 6;
  localparam int REG_LSB = 1;
  localparam int ENA_BIT = 0;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] value;
    logic [4:0]  rd;
    logic        ena;
  } trace_rec_t;
endpackage

// File: rtl/wb_trace_buffer_if.sv
// wb_trace_buffer_if: retirement capture inputs and trace stream outputs
interface wb_trace_buffer_if #(parameter int DEPTH = 16);
  import wb_trace_buffer_pkg::*;
  logic                       debug_wb_have_inst;
  logic [31:0]                debug_wb_pc;
  logic                       debug_wb_ena;
  logic [4:0]                 debug_wb_reg;
  logic [31:0]                debug_wb_value;
  logic                       trace_clr;
  logic                       trace_ready;
  logic                       trace_valid;
  logic [TRACE_REC_W-1:0]     trace_data;
  logic [$clog2(DEPTH):0]     trace_level;
  logic                       trace_overflow;
  logic [15:0]                trace_drop_cnt;
  modport master (
    output debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value,
    output trace_clr, trace_ready,
    input  trace_valid, trace_data, trace_level, trace_overflow, trace_drop_cnt
  );
  modport slave (
    input  debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value,
    input  trace_clr, trace_ready,
    output trace_valid, trace_data, trace_level, trace_overflow, trace_drop_cnt
  );
endinterface

// File: rtl/wb_trace_buffer_fifo.sv
// trace_sync_fifo: first-word-fall-through sync FIFO with occupancy output
module trace_sync_fifo #(
  parameter int W = 70,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [AW:0]  level,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  assign level = wp - rp;
  assign full  = level == (AW+1)'(DEPTH);
  assign empty = wp == rp;
  assign dout  = mem[rp[AW-1:0]];
  // pointers carry an extra MSB so full and empty stay distinguishable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
    end
  // storage needs no reset; the head is only meaningful while non-empty
  always_ff @(posedge clk)
    if (push && !clr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: retirement trace FIFO with drop counting; WB_TRACE_DROP_NOWB_EN captures only register-writing retirements
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  wb_trace_buffer_if.slave  bus
);
  trace_rec_t rec;
  logic cap, pop, full, empty, drop;
  assign rec = '{pc: bus.debug_wb_pc, value: bus.debug_wb_value, rd: bus.debug_wb_reg, ena: bus.debug_wb_ena};
`ifdef WB_TRACE_DROP_NOWB_EN
  assign cap = bus.debug_wb_have_inst && bus.debug_wb_ena;
`else
  assign cap = bus.debug_wb_have_inst;
`endif
  assign pop  = bus.trace_valid && bus.trace_ready;
  assign drop = cap && full && !pop;
  assign bus.trace_valid = !empty;
  trace_sync_fifo #(.W(TRACE_REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.trace_clr),
    .push  (cap && !drop),
    .pop   (pop),
    .din   (rec),
    .dout  (bus.trace_data),
    .level (bus.trace_level),
    .full  (full),
    .empty (empty)
  );
  // sticky overflow and saturating drop count, both cleared by flush
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.trace_overflow <= 1'b0;
      bus.trace_drop_cnt <= '0;
    end else if (bus.trace_clr) begin
      bus.trace_overflow <= 1'b0;
      bus.trace_drop_cnt <= '0;
    end else if (drop) begin
      bus.trace_overflow <= 1'b1;
      if (bus.trace_drop_cnt != 16'hFFFF) bus.trace_drop_cnt <= bus.trace_drop_cnt + 16'd1;
    end
endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the FIFO entry count; it SHALL be a power of two, at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, shared with the CPU core.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port debug_wb_have_inst, input, 1 bit: an instruction retired this cycle.
REQ-005 The block SHALL have port debug_wb_pc, input, 32 bits: PC of the retired instruction.
REQ-006 The block SHALL have port debug_wb_ena, input, 1 bit: register-file write enable of the retired instruction.
REQ-007 The block SHALL have port debug_wb_reg, input, 5 bits: destination register number.
REQ-008 The block SHALL have port debug_wb_value, input, 32 bits: value written to the destination register.
REQ-009 The block SHALL have port trace_clr, input, 1 bit: synchronous flush.
REQ-010 The block SHALL have port trace_ready, input, 1 bit: the consumer accepts the head record.
REQ-011 The block SHALL have port trace_valid, output, 1 bit: the head record is available.
REQ-012 The block SHALL have port trace_data, output, 70 bits: {pc[69:38], value[37:6], reg[5:1], ena[0]}.
REQ-013 The block SHALL have port trace_level, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-014 The block SHALL have port trace_overflow, output, 1 bit: sticky flag meaning at least one record was dropped.
REQ-015 The block SHALL have port trace_drop_cnt, output, 16 bits: count of dropped records, saturating.

Function
REQ-016 A push SHALL be requested on every rising clk edge where debug_wb_have_inst=1 (capture condition), and that push SHALL store the packed record per REQ-012.
REQ-017 The FIFO SHALL be first-word-fall-through: trace_valid SHALL equal (level!=0), and trace_data SHALL present the head record combinationally from storage.
REQ-018 A pop SHALL occur when trace_valid=1 and trace_ready=1 at the clock edge, and trace_data SHALL NOT change while trace_valid=1 and trace_ready=0.
REQ-019 A push accepted into an empty FIFO SHALL assert trace_valid in the following cycle (one-cycle latency).
REQ-020 On a push while full with no pop, the block SHALL discard the record, set trace_overflow, and increment trace_drop_cnt, saturating at 16'hFFFF.
REQ-021 On a push and pop in the same cycle while full, both SHALL be performed, with no drop and the level unchanged.
REQ-022 On a push and pop in the same cycle while non-full, both SHALL be performed, with the level unchanged.
REQ-023 A pop while empty SHALL be impossible by REQ-018, and the level SHALL NOT underflow.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH, and full and empty SHALL be derived from an extra pointer MSB or from the level.
REQ-025 When trace_clr=1, at the clock edge the block SHALL empty the FIFO and clear trace_overflow and trace_drop_cnt, with any same-cycle push or pop ignored.
REQ-026 trace_level SHALL equal the number of stored records after each edge, ranging from 0 to DEPTH.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force the pointers, level, trace_overflow, and trace_drop_cnt to 0, and trace_valid to 0.
REQ-028 Storage contents SHALL NOT require reset, and trace_data SHALL be don't-care while trace_valid=0.
REQ-029 The block SHALL accept no push while rst_n=0, and on a reset mid-stream it SHALL lose all queued records silently, without counting them as drops.

Configuration
REQ-030 When macro WB_TRACE_DROP_NOWB_EN is defined, the capture condition SHALL be debug_wb_have_inst=1 AND debug_wb_ena=1, so retirements that do not write a register are neither stored nor counted as drops.
REQ-031 When WB_TRACE_DROP_NOWB_EN is undefined, the capture condition SHALL be per REQ-016, and records with ena=0 SHALL be stored.

Structure
REQ-032 The shared package SHALL hold: the TRACE_REC_W=70 constant, the field offset constants (PC_LSB=38, VAL_LSB=6, REG_LSB=1, ENA_BIT=0), and the packed trace record typedef.
REQ-033 Storage SHALL be one sub-module, trace_sync_fifo (parameterised width and depth, FWFT, with level output); the drop and overflow logic SHALL stay in the top module.

Verification
REQ-034 The bench SHALL cover: after reset, 3 retirements with pc=0x0,0x4,0x8, reg=1..3, value=0x11,0x22,0x33, and trace_ready=1 -> 3 records emerge in order, each one cycle after capture, with level returning to 0.
REQ-035 The bench SHALL cover: trace_ready=0 and 18 consecutive retirements at DEPTH=16 -> level=16, trace_overflow=1, trace_drop_cnt=2, and the head record is still the first pc.
REQ-036 The bench SHALL cover: full FIFO with a push and a pop in the same cycle -> drop_cnt unchanged, level stays 16, and the new record lands at the tail.
REQ-037 The bench SHALL cover: trace_clr=1 with level=5 and overflow=1 -> next cycle level=0, trace_valid=0, overflow=0, and drop_cnt=0.
REQ-038 The bench SHALL cover: with WB_TRACE_DROP_NOWB_EN defined, 4 retirements with ena=1,0,1,0 -> exactly 2 records stored; with the macro undefined, 4 records are stored.
REQ-039 The bench SHALL cover: rst_n pulsed low asynchronously with level=7 -> level=0 and valid=0 immediately, without waiting for a clock edge.
